// File: rtl/tx_sched_pkg.sv
// Shared types and fixed ordered-set symbols for the TX ordered-set scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_OS_SEND = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OS_NONE  = 2'd0,
    OS_SKP   = 2'd1,
    OS_TS    = 2'd2,
    OS_EIEOS = 2'd3
  } os_type_e;

  // Per-lane symbols; EIEOS alternates 00/FF across lanes starting at lane 0.
  localparam logic [7:0] SKP_SYM        = 8'hAA;
  localparam logic [7:0] EIEOS_SYM_EVEN = 8'h00;
  localparam logic [7:0] EIEOS_SYM_ODD  = 8'hFF;

endpackage

// File: rtl/os_payload_mux.sv
// Selects the ordered-set payload by type; zero whenever no OS is driven.
module os_payload_mux
  import tx_sched_pkg::*;
#(
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned MAX_LANES    = 32
) (
  input  os_type_e                            i_Os_Type,
  input  logic                                i_Enable,
  input  logic [SYMBOL_WIDTH*MAX_LANES-1:0]   i_TS_OS,
  output logic [SYMBOL_WIDTH*MAX_LANES-1:0]   o_OS
);

  localparam int unsigned OS_W = SYMBOL_WIDTH * MAX_LANES;

  logic [OS_W-1:0] w_skp_pat;
  logic [OS_W-1:0] w_eieos_pat;

  for (genvar l = 0; l < MAX_LANES; l++) begin : g_lane
    assign w_skp_pat[l*SYMBOL_WIDTH +: SYMBOL_WIDTH] = SYMBOL_WIDTH'(SKP_SYM);
    if ((l % 2) == 0) begin : g_even
      assign w_eieos_pat[l*SYMBOL_WIDTH +: SYMBOL_WIDTH] = SYMBOL_WIDTH'(EIEOS_SYM_EVEN);
    end else begin : g_odd
      assign w_eieos_pat[l*SYMBOL_WIDTH +: SYMBOL_WIDTH] = SYMBOL_WIDTH'(EIEOS_SYM_ODD);
    end
  end

  always_comb begin
    o_OS = '0;
    if (i_Enable) begin
      case (i_Os_Type)
        OS_SKP:   o_OS = w_skp_pat;
        OS_TS:    o_OS = i_TS_OS;
        OS_EIEOS: o_OS = w_eieos_pat;
        default:  o_OS = '0;
      endcase
    end
  end

endmodule

// File: rtl/tx_os_scheduler.sv
// Arbitrates the TX datapath between DLL data blocks and SKP/TS/EIEOS ordered sets,
// waiting for packet boundaries before inserting an OS.
module tx_os_scheduler
  import tx_sched_pkg::*;
#(
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned MAX_LANES    = 32,
  parameter int unsigned SKP_INTERVAL = 370,
  parameter int unsigned OS_CYCLES    = 1,
  parameter int unsigned CNT_WIDTH    = 9
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              i_EN,
  input  logic                              i_Data_Req,
  input  logic                              i_Pkt_Boundary,
  input  logic                              i_TS_Req,
  input  logic [SYMBOL_WIDTH*MAX_LANES-1:0] i_TS_OS,
  input  logic                              i_EIEOS_Req,
  input  logic                              i_Tx_Full,
  output logic                              o_Data_Grant,
  output logic                              o_Os_Enable,
  output logic [SYMBOL_WIDTH*MAX_LANES-1:0] o_OS,
  output logic [1:0]                        o_Os_Type,
  output logic                              o_Idle_Cnt_Enable,
  output logic                              o_Skp_Pending
);

  localparam int unsigned OCW = (OS_CYCLES > 1) ? $clog2(OS_CYCLES) : 1;

  state_e               r_state;
  os_type_e             r_os_type;
  logic [CNT_WIDTH-1:0] r_skp_cnt;
  logic [OCW-1:0]       r_os_cnt;
  logic                 r_skp_pend;
  logic                 r_eieos_pend;

  logic     w_data_st;
  logic     w_grant;
  logic     w_idle;
  logic     w_os_en;
  logic     w_skp_hit;
  logic     w_os_done;
  logic     w_eieos_nxt;
  logic     w_skp_nxt;
  logic     w_any_pend;
  os_type_e w_sel;

  // Pending-flag lookahead: includes this cycle's arrivals and excludes the OS just finished.
  always_comb begin
    w_data_st   = (r_state == ST_DATA) || (r_state == ST_DRAIN);
    w_grant     = w_data_st && i_Data_Req && !i_Tx_Full;
    w_idle      = w_data_st && !i_Data_Req && !i_Tx_Full;
    w_os_en     = (r_state == ST_OS_SEND) && !i_Tx_Full;
    w_skp_hit   = (r_state == ST_DATA) && !i_Tx_Full &&
                  (r_skp_cnt == CNT_WIDTH'(SKP_INTERVAL - 1));
    w_os_done   = w_os_en && (r_os_cnt == OCW'(OS_CYCLES - 1));
    w_eieos_nxt = (r_eieos_pend || i_EIEOS_Req) && !(w_os_done && (r_os_type == OS_EIEOS));
    w_skp_nxt   = (r_skp_pend || w_skp_hit) && !(w_os_done && (r_os_type == OS_SKP));
    w_any_pend  = w_eieos_nxt || i_TS_Req || w_skp_nxt;
    w_sel       = OS_NONE;
    if (w_eieos_nxt) begin
      w_sel = OS_EIEOS;
    end else if (i_TS_Req) begin
      w_sel = OS_TS;
    end else if (w_skp_nxt) begin
      w_sel = OS_SKP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || !i_EN) begin
      r_state      <= ST_IDLE;
      r_os_type    <= OS_NONE;
      r_skp_cnt    <= '0;
      r_os_cnt     <= '0;
      r_skp_pend   <= 1'b0;
      r_eieos_pend <= 1'b0;
    end else begin
      r_eieos_pend <= w_eieos_nxt;
      r_skp_pend   <= w_skp_nxt;
      if ((r_state == ST_DATA) && !i_Tx_Full) begin
        r_skp_cnt <= w_skp_hit ? '0 : r_skp_cnt + CNT_WIDTH'(1);
      end
      if (w_os_en) begin
        r_os_cnt <= w_os_done ? '0 : r_os_cnt + OCW'(1);
      end
      case (r_state)
        ST_IDLE: r_state <= ST_DATA;
        ST_DATA: begin
          if (w_any_pend) begin
            if (i_Pkt_Boundary) begin
              r_state   <= ST_OS_SEND;
              r_os_type <= w_sel;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // A request that went away while draining sends us back to plain data.
          if (i_Pkt_Boundary && w_grant) begin
            if (w_any_pend) begin
              r_state   <= ST_OS_SEND;
              r_os_type <= w_sel;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_OS_SEND: begin
          if (w_os_done) begin
            if (w_any_pend) begin
              r_os_type <= w_sel;
            end else begin
              r_state   <= ST_DATA;
              r_os_type <= OS_NONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic w_os_en_out;
  assign w_os_en_out       = !RST && w_os_en;
  assign o_Data_Grant      = !RST && w_grant;
  assign o_Idle_Cnt_Enable = !RST && w_idle;
  assign o_Os_Enable       = w_os_en_out;
  assign o_Os_Type         = w_os_en_out ? r_os_type : OS_NONE;
  assign o_Skp_Pending     = r_skp_pend;

  os_payload_mux #(
    .SYMBOL_WIDTH (SYMBOL_WIDTH),
    .MAX_LANES    (MAX_LANES)
  ) u_os_payload_mux (
    .i_Os_Type (r_os_type),
    .i_Enable  (w_os_en_out),
    .i_TS_OS   (i_TS_OS),
    .o_OS      (o_OS)
  );

endmodule

// File: tb/tb_tx_os_scheduler.sv
// Scoreboard bench for tx_os_scheduler: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_tx_os_scheduler;

  localparam int unsigned SW   = 8;
  localparam int unsigned NL   = 32;
  localparam int unsigned OS_W = SW * NL;

  localparam logic [OS_W-1:0] TS_PAT    = {8{32'h4A5B6C7D}};
  localparam logic [OS_W-1:0] SKP_PAT   = {32{8'hAA}};
  localparam logic [OS_W-1:0] EIEOS_PAT = {16{8'hFF, 8'h00}};

  logic            CLK = 1'b0;
  logic            RST;
  logic            i_EN, i_Data_Req, i_Pkt_Boundary, i_TS_Req, i_EIEOS_Req, i_Tx_Full;
  logic [OS_W-1:0] i_TS_OS;
  logic            o_Data_Grant, o_Os_Enable, o_Idle_Cnt_Enable, o_Skp_Pending;
  logic [OS_W-1:0] o_OS;
  logic [1:0]      o_Os_Type;

  tx_os_scheduler #(
    .SYMBOL_WIDTH (SW),
    .MAX_LANES    (NL),
    .SKP_INTERVAL (4),
    .OS_CYCLES    (1),
    .CNT_WIDTH    (9)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .i_EN              (i_EN),
    .i_Data_Req        (i_Data_Req),
    .i_Pkt_Boundary    (i_Pkt_Boundary),
    .i_TS_Req          (i_TS_Req),
    .i_TS_OS           (i_TS_OS),
    .i_EIEOS_Req       (i_EIEOS_Req),
    .i_Tx_Full         (i_Tx_Full),
    .o_Data_Grant      (o_Data_Grant),
    .o_Os_Enable       (o_Os_Enable),
    .o_OS              (o_OS),
    .o_Os_Type         (o_Os_Type),
    .o_Idle_Cnt_Enable (o_Idle_Cnt_Enable),
    .o_Skp_Pending     (o_Skp_Pending)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0] ex;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [OS_W-1:0] exp_os(input logic [1:0] ty);
    case (ty)
      2'd1:    return SKP_PAT;
      2'd2:    return TS_PAT;
      2'd3:    return EIEOS_PAT;
      default: return '0;
    endcase
  endfunction

  // in = {rst,en,data_req,boundary,ts_req,eieos_req,tx_full}
  // ex = {grant,os_en,os_type[1:0],idle_en,skp_pending}
  task automatic cyc(input logic [6:0] in, input logic [5:0] ex, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    RST            = in[6];
    i_EN           = in[5];
    i_Data_Req     = in[4];
    i_Pkt_Boundary = in[3];
    i_TS_Req       = in[2];
    i_EIEOS_Req    = in[1];
    i_Tx_Full      = in[0];
    e.ex = ex;
    e.nm = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t            e;
    logic [5:0]      got;
    logic [OS_W-1:0] eos;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {o_Data_Grant, o_Os_Enable, o_Os_Type, o_Idle_Cnt_Enable, o_Skp_Pending};
        eos = exp_os(e.ex[3:2]);
        checks++;
        if (got !== e.ex || o_OS !== eos) begin
          errors++;
          $display("FAIL %s: got g/oe/ty/idle/skp=%b os=%h expected %b os=%h",
                   e.nm, got, o_OS, e.ex, eos);
        end
      end
    end
  end

  initial begin : stim
    int k;
    RST = 1'b1; i_EN = 1'b0; i_Data_Req = 1'b0; i_Pkt_Boundary = 1'b0;
    i_TS_Req = 1'b0; i_EIEOS_Req = 1'b0; i_Tx_Full = 1'b0; i_TS_OS = TS_PAT;
    repeat (2) @(posedge CLK);

    // Reset overrides enable and requests; enable low holds IDLE
    cyc(7'b1111010, 6'b000000, "rst_override");
    cyc(7'b0000000, 6'b000000, "idle_en_low");
    cyc(7'b0111000, 6'b000000, "idle_to_data");

    // SKP every 4 granted cycles
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) cyc(7'b0111000, 6'b100000, "skp_grant");
      cyc(7'b0111000, 6'b010101, "skp_os");
    end

    // Idle blocks, backpressure, and 5-cycle stall inside an SKP OS
    cyc(7'b0101000, 6'b000010, "idle_block");
    cyc(7'b0111001, 6'b000000, "full_in_data");
    for (int j = 0; j < 3; j++) cyc(7'b0111000, 6'b100000, "pre_stall_grant");
    for (int j = 0; j < 5; j++) cyc(7'b0111001, 6'b000001, "os_stalled");
    cyc(7'b0111000, 6'b010101, "skp_after_stall");
    for (int j = 0; j < 4; j++) cyc(7'b0111000, 6'b100000, "cnt_held_grant");
    cyc(7'b0111000, 6'b010101, "skp_cnt_held");

    // EIEOS mid-packet: 3 DRAIN cycles, second pulse absorbed
    cyc(7'b0110010, 6'b100000, "eieos_pulse");
    cyc(7'b0110010, 6'b100000, "drain_absorb");
    cyc(7'b0110000, 6'b100000, "drain");
    cyc(7'b0111000, 6'b100000, "drain_boundary");
    cyc(7'b0111000, 6'b011100, "eieos_os");
    cyc(7'b0111000, 6'b100000, "no_second_eieos");

    // EIEOS, TS and SKP all pending -> 3,2,1 back to back
    cyc(7'b0111000, 6'b100000, "pre_all");
    cyc(7'b0111110, 6'b100000, "all_pending");
    cyc(7'b0111100, 6'b011101, "prio_eieos");
    cyc(7'b0111000, 6'b011001, "prio_ts");
    cyc(7'b0111000, 6'b010101, "prio_skp");
    cyc(7'b0111000, 6'b100000, "after_prio");

    // Enable dropped during a TS OS with SKP pending
    cyc(7'b0111000, 6'b100000, "pre_ts");
    cyc(7'b0111000, 6'b100000, "pre_ts");
    cyc(7'b0111100, 6'b100000, "ts_and_skp_hit");
    cyc(7'b0011100, 6'b011001, "ts_os_en_drop");
    cyc(7'b0000000, 6'b000000, "en_drop_idle");
    cyc(7'b0111000, 6'b000000, "reenable");
    cyc(7'b0111000, 6'b100000, "data_after_en");

    // Reset mid-DRAIN restarts SKP count from 0
    cyc(7'b0110100, 6'b100000, "to_drain");
    cyc(7'b1110100, 6'b000000, "rst_in_drain");
    cyc(7'b0111000, 6'b000000, "post_rst_idle");
    for (int j = 0; j < 4; j++) cyc(7'b0111000, 6'b100000, "post_rst_grant");
    cyc(7'b0111000, 6'b010101, "post_rst_skp");
    cyc(7'b0011000, 6'b100000, "en_low_data");
    cyc(7'b0000000, 6'b000000, "final_idle");

    k = 0;
    while (q.size() != 0 && k < 10) begin
      @(posedge CLK);
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
